// File: rtl/ser_frame_arbiter.sv
// Round-robin arbiter and sequencer for one bit-serial device window (select, command, data).
// Latency: SSER falls one clock after acceptance; rsp_valid (CMD_W+DATA_W+2)*2*CLK_DIV clocks after acceptance.
// Backpressure: ready is offered to one requester only while IDLE; all other requests wait with fields held.
module ser_frame_arbiter #(
    parameter int CMD_W   = 8,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_rd,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_rd,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              SSER,
    output logic              SCLK,
    output logic              SDO,
    input  logic              SDRD
);

    // Divider spans one full bit period: low half then high half of SCLK.
    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int BIT_MAX = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] CMD_LAST = BIT_W'(CMD_W - 1);
    localparam logic [BIT_W-1:0] DAT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_CMD  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                last_q, last_d;
    logic                id_q, id_d;
    logic                rd_q, rd_d;
    logic [CMD_W-1:0]    cmd_sh_q, cmd_sh_d;
    logic [DATA_W-1:0]   wd_sh_q, wd_sh_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic period_end;
    logic sclk_rise;
    logic in_frame;
    logic grant0;
    logic grant1;
    logic accept;

    assign period_end = (div_q == DIV_LAST);
    assign sclk_rise  = (div_q == DIV_HALF);
    assign in_frame   = (state_q == S_SEL) || (state_q == S_CMD) || (state_q == S_DATA);

    // Round-robin choice: under contention the requester not served last wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_q);
        grant1 = req1_valid & (~req0_valid | ~last_q);
        accept = (state_q == S_IDLE) & ~rst & (grant0 | grant1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each phase ends on the last clock of its last bit period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)                           state_d = S_SEL;
            S_SEL:  if (period_end)                       state_d = S_CMD;
            S_CMD:  if (period_end && bit_q == CMD_LAST)  state_d = S_DATA;
            S_DATA: if (period_end && bit_q == DAT_LAST)  state_d = S_DONE;
            S_DONE: if (period_end)                       state_d = S_IDLE;
            default:                                      state_d = S_IDLE;
        endcase
    end

    // Outputs: serial pins, ready strobes and the completion pulse.
    always_comb begin
        SSER       = ~in_frame;
        SCLK       = in_frame & (div_q >= DIV_HALF);
        SDO        = 1'b0;
        if (state_q == S_CMD) begin
            SDO = cmd_sh_q[CMD_W-1];
        end else if (state_q == S_DATA && !rd_q) begin
            SDO = wd_sh_q[DATA_W-1];
        end
        req0_ready = (state_q == S_IDLE) & ~rst & grant0;
        req1_ready = (state_q == S_IDLE) & ~rst & grant1;
        rsp_valid  = (state_q == S_DONE) & period_end;
        rsp_id     = rsp_valid & id_q;
        rsp_rdata  = (rsp_valid && rd_q) ? rdata_q : '0;
    end

    // Datapath: divider, bit counter, shift registers, request latch and pointer.
    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        last_d   = last_q;
        id_d     = id_q;
        rd_d     = rd_q;
        cmd_sh_d = cmd_sh_q;
        wd_sh_d  = wd_sh_q;
        rdata_d  = rdata_q;

        // Divider idles at zero so every frame starts on a fresh low half-period.
        if (state_q == S_IDLE || period_end) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        // Bit counter restarts on every phase change.
        if (state_d != state_q) begin
            bit_d = '0;
        end else if (period_end && (state_q == S_CMD || state_q == S_DATA)) begin
            bit_d = bit_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d     = grant1;
                    rd_d     = grant1 ? req1_rd    : req0_rd;
                    cmd_sh_d = grant1 ? req1_cmd   : req0_cmd;
                    wd_sh_d  = grant1 ? req1_wdata : req0_wdata;
                    rdata_d  = '0;
                end
            end
            S_CMD: begin
                // Shift at period end so SDO only moves at the start of a period.
                if (period_end) begin
                    cmd_sh_d = {cmd_sh_q[CMD_W-2:0], 1'b0};
                end
            end
            S_DATA: begin
                if (period_end && !rd_q) begin
                    wd_sh_d = {wd_sh_q[DATA_W-2:0], 1'b0};
                end
                // First sampled bit ends up as the MSB after DATA_W shifts.
                if (sclk_rise && rd_q) begin
                    rdata_d = {rdata_q[DATA_W-2:0], SDRD};
                end
            end
            S_DONE: begin
                if (period_end) begin
                    last_d = id_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            bit_q    <= '0;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            rd_q     <= 1'b0;
            cmd_sh_q <= '0;
            wd_sh_q  <= '0;
            rdata_q  <= '0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            last_q   <= last_d;
            id_q     <= id_d;
            rd_q     <= rd_d;
            cmd_sh_q <= cmd_sh_d;
            wd_sh_q  <= wd_sh_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
